branch_redirect_sequencer: RTL

Sits between the execute-stage branch controller and the fetch unit. It turns a single-cycle take-branch/flush pulse into a held redirect handshake with fetch. It then squashes stale wrong-path fetch responses for a fixed drain window. It also keeps a saturating count of redirects for performance monitoring.

---
 rtl/branch_redirect_sequencer_pkg.sv | 23 ++
 rtl/branch_redirect_sequencer_sat_counter.sv | 36 +++
 rtl/branch_redirect_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/branch_redirect_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// branch_redirect_sequencer_pkg : shared redirect types and sizing helpers
// Rev 1.0
// ============================================================================
package branch_redirect_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } redirect_state_e;

    typedef logic take_branch_ctrl_sig;
    typedef logic flush_pipeline_sig;

    // A zero-length drain still needs a 1-bit counter to keep the datapath legal.
    function automatic int drain_width(input int flush_cycles);
        return (flush_cycles < 1) ? 1 : $clog2(flush_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_redirect_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : W-bit event counter that sticks at all-ones
// Rev 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/branch_redirect_sequencer.sv
`default_nettype none
// ============================================================================
// branch_redirect_sequencer : branch pulse -> held fetch redirect + drain squash
// Rev 1.0
// ============================================================================
module branch_redirect_sequencer
    import branch_redirect_sequencer_pkg::*;
#(
    parameter int WORD         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  take_branch_ctrl_sig take_branch_i,
    input  logic [WORD-1:0]     target_pc_i,
    input  logic                redirect_ready_i,
    output logic                redirect_valid_o,
    output logic [WORD-1:0]     redirect_pc_o,
    output flush_pipeline_sig   flush_fetch_o,
    output flush_pipeline_sig   flush_decode_o,
    output logic                busy_o,
    output logic [CNT_W-1:0]    redirect_count_o
);

    localparam int                 DRAIN_W    = drain_width(FLUSH_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(FLUSH_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

    redirect_state_e     state_q, state_d;
    logic [WORD-1:0]     pc_q, pc_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                handshake;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drain_d   = drain_q;
        handshake = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take_branch_i) begin
                    pc_d    = {target_pc_i[WORD-1:1], 1'b0};
                    state_d = ST_REDIRECT;
                end
            end
            // Branches seen here come from the wrong path and are dropped.
            ST_REDIRECT: begin
                if (redirect_ready_i) begin
                    handshake = 1'b1;
                    if (FLUSH_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_INIT;
                    end
                end
            end
            ST_DRAIN: begin
                if (take_branch_i) begin
                    pc_d    = {target_pc_i[WORD-1:1], 1'b0};
                    state_d = ST_REDIRECT;
                end else if (drain_q == DRAIN_ONE) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q - DRAIN_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drain_q <= drain_d;
        end
    end

    assign redirect_valid_o = (state_q == ST_REDIRECT);
    assign flush_decode_o   = (state_q == ST_REDIRECT);
    assign flush_fetch_o    = (state_q != ST_IDLE);
    assign busy_o           = (state_q != ST_IDLE);
    assign redirect_pc_o    = (state_q == ST_IDLE) ? '0 : pc_q;

    sat_counter #(
        .W (CNT_W)
    ) u_redirect_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (handshake),
        .count_o (redirect_count_o)
    );

endmodule
`default_nettype wire
